i2c_paddle_reader: RTL and testbench

I2C master that periodically polls a paddle controller (ADC/joystick slave) and presents the latest paddle position to the pong game core. It sits directly upstream of the game core and drives the chip's open-drain SDA/SCL pad pair. Each poll is a fixed 2-byte read. The game core consumes the position and button outputs, qualified by a single-cycle strobe.

---
 rtl/pong_i2c_pkg.sv | 50 +++++
 rtl/i2c_paddle_reader_if.sv | 10 +
 rtl/i2c_tick_gen.sv | 40 ++++
 rtl/i2c_paddle_reader.sv | 195 +++++++++++++++++++
 tb/tb_i2c_paddle_reader.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_i2c_pkg.sv
// Shared types and constants for the paddle-poll I2C master: FSM states, quarter-phase
// encoding, bus bit meanings and the paddle reset position.
package pong_i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StAddr,
    StAddrAck,
    StRd0,
    StMack0,
    StRd1,
    StMnack1,
    StStop
  } i2c_state_t;

  typedef enum logic [1:0] {
    PhQ0 = 2'd0,
    PhQ1 = 2'd1,
    PhQ2 = 2'd2,
    PhQ3 = 2'd3
  } i2c_phase_t;

  localparam logic I2C_RD   = 1'b1;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [7:0] PADDLE_CENTER = 8'h80;

  // Successor of a frame segment once its last quarter completes.
  function automatic i2c_state_t next_state(i2c_state_t s, logic addr_nack);
    i2c_state_t n;
    case (s)
      StStart:   n = StAddr;
      StAddr:    n = StAddrAck;
      StAddrAck: n = addr_nack ? StStop : StRd0;
      StRd0:     n = StMack0;
      StMack0:   n = StRd1;
      StRd1:     n = StMnack1;
      StMnack1:  n = StStop;
      default:   n = StIdle;
    endcase
    return n;
  endfunction

  function automatic logic is_byte_state(i2c_state_t s);
    return s inside {StAddr, StRd0, StRd1};
  endfunction

endpackage

// File: rtl/i2c_paddle_reader_if.sv
// Open-drain I2C pad pair: *_oe = 1 pulls the line low, *_i reads the resolved line.
interface i2c_paddle_reader_if;
  logic sda_i;
  logic sda_oe;
  logic scl_i;
  logic scl_oe;

  modport master (input sda_i, input scl_i, output sda_oe, output scl_oe);
  modport slave  (output sda_i, output scl_i, input sda_oe, input scl_oe);
endinterface

// File: rtl/i2c_tick_gen.sv
// SCL quarter-period divider: counts 0..CLK_DIV while enabled, one-clk tick at wrap.
// clr_i zeroes the count; hold_i freezes it (clock stretching).
module i2c_tick_gen #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            run;

  assign run    = en_i && !hold_i && !clr_i;
  assign tick_o = run && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_paddle_reader.sv
// Periodic 2-byte I2C read of the paddle controller; publishes position/button on success.
// Optional macro CLK_STRETCH_EN: honour slave clock stretching on every SCL release.
module i2c_paddle_reader
  import pong_i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 8,
  parameter logic [6:0]  SLAVE_ADDR  = 7'h52,
  parameter int unsigned POLL_CYCLES = 416666
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  i2c_paddle_reader_if.master        bus,
  output logic [7:0]                 paddle_pos,
  output logic                       button,
  output logic                       pos_valid,
  output logic                       nack_err,
  output logic                       busy
);

  localparam logic [23:0] PollLast = 24'(POLL_CYCLES - 1);
  localparam logic [7:0]  AddrByte = {SLAVE_ADDR, I2C_RD};

  i2c_state_t  state_q, state_d;
  i2c_phase_t  phase_q, phase_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic [23:0] poll_q, poll_d;
  logic        ack_fail_q, ack_fail_d;
  logic [7:0]  pos_q, pos_d;
  logic        button_q, button_d;
  logic        pos_valid_q, pos_valid_d;
  logic        nack_q, nack_d;
  logic        start_poll, tick, scl_hold;
  logic        sda_low, scl_low;

  assign busy = (state_q != StIdle);

`ifdef CLK_STRETCH_EN
  // Freeze the quarter while SCL is released but still held low by the slave.
  assign scl_hold = (state_q inside {StAddr, StAddrAck, StRd0, StMack0, StRd1, StMnack1, StStop})
                    && (phase_q == PhQ1) && !bus.scl_i;
`else
  logic unused_scl;
  assign unused_scl = bus.scl_i;
  assign scl_hold   = 1'b0;
`endif

  i2c_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .en_i   (busy),
    .clr_i  (start_poll),
    .hold_i (scl_hold),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    poll_d      = poll_q;
    ack_fail_d  = ack_fail_q;
    pos_d       = pos_q;
    button_d    = button_q;
    pos_valid_d = 1'b0;
    nack_d      = nack_q;
    start_poll  = 1'b0;

    if (state_q == StIdle) begin
      // Interval is measured from IDLE entry; disabling restarts it from zero.
      if (!enable) begin
        poll_d = '0;
      end else if (poll_q == PollLast) begin
        poll_d     = '0;
        start_poll = 1'b1;
        state_d    = StStart;
        phase_d    = PhQ0;
        bit_d      = '0;
        ack_fail_d = 1'b0;
      end else begin
        poll_d = poll_q + 24'd1;
      end
    end else if (tick) begin
      phase_d = i2c_phase_t'(phase_q + 2'd1);
      if (phase_q == PhQ2) begin
        if (state_q inside {StRd0, StRd1}) begin
          shift_d = {shift_q[6:0], bus.sda_i};
        end
        if (state_q == StAddrAck) begin
          ack_fail_d = (bus.sda_i == I2C_NACK);
        end
      end
      if (phase_q == PhQ3) begin
        if (state_q == StStop) begin
          state_d = StIdle;
          if (ack_fail_q) begin
            nack_d = 1'b1;
          end else begin
            pos_d       = hold_q;
            button_d    = shift_q[0];
            pos_valid_d = 1'b1;
            nack_d      = 1'b0;
          end
        end else if (bit_q != 3'd0) begin
          bit_d = bit_q - 3'd1;
        end else begin
          state_d = next_state(state_q, ack_fail_q);
          bit_d   = is_byte_state(state_d) ? 3'd7 : 3'd0;
          if (state_q == StRd0) begin
            hold_d = shift_q;
          end
        end
      end
    end
  end

  // Pad drive decode; a 1 only ever pulls a line low.
  always_comb begin
    sda_low = 1'b0;
    scl_low = 1'b0;
    unique case (state_q)
      StIdle: begin
        sda_low = 1'b0;
        scl_low = 1'b0;
      end
      StStart: begin
        sda_low = (phase_q != PhQ0);
        scl_low = phase_q inside {PhQ2, PhQ3};
      end
      StStop: begin
        sda_low = phase_q inside {PhQ0, PhQ1};
        scl_low = (phase_q == PhQ0);
      end
      StAddr: begin
        sda_low = !AddrByte[bit_q];
        scl_low = phase_q inside {PhQ0, PhQ3};
      end
      StMack0: begin
        sda_low = (I2C_ACK == 1'b0);
        scl_low = phase_q inside {PhQ0, PhQ3};
      end
      StMnack1: begin
        sda_low = (I2C_NACK == 1'b0);
        scl_low = phase_q inside {PhQ0, PhQ3};
      end
      default: begin
        sda_low = 1'b0;
        scl_low = phase_q inside {PhQ0, PhQ3};
      end
    endcase
  end

  assign bus.sda_oe = sda_low;
  assign bus.scl_oe = scl_low;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      phase_q     <= PhQ0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      poll_q      <= '0;
      ack_fail_q  <= 1'b0;
      pos_q       <= PADDLE_CENTER;
      button_q    <= 1'b0;
      pos_valid_q <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      poll_q      <= poll_d;
      ack_fail_q  <= ack_fail_d;
      pos_q       <= pos_d;
      button_q    <= button_d;
      pos_valid_q <= pos_valid_d;
      nack_q      <= nack_d;
    end
  end

  assign paddle_pos = pos_q;
  assign button     = button_q;
  assign pos_valid  = pos_valid_q;
  assign nack_err   = nack_q;

endmodule

// File: tb/tb_i2c_paddle_reader.sv
// Directed/randomized bench for i2c_paddle_reader with a bus-level I2C slave model.
module tb_i2c_paddle_reader;

  localparam int unsigned DIV  = 3;
  localparam int unsigned POLL = 2000;
  localparam logic [7:0]  EXP_ADDR = {7'h52, 1'b1};
`ifdef CLK_STRETCH_EN
  localparam int StretchExtra = 50;
`else
  localparam int StretchExtra = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       slave_low;
  logic       stretch = 1'b0;
  logic [7:0] paddle_pos;
  logic       button, pos_valid, nack_err, busy;

  i2c_paddle_reader_if bus ();

  assign bus.sda_i = !(bus.sda_oe || slave_low);
  assign bus.scl_i = !(bus.scl_oe || stretch);

  i2c_paddle_reader #(
    .CLK_DIV     (DIV),
    .SLAVE_ADDR  (7'h52),
    .POLL_CYCLES (POLL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .bus        (bus),
    .paddle_pos (paddle_pos),
    .button     (button),
    .pos_valid  (pos_valid),
    .nack_err   (nack_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;

  // Slave behaviour for the current frame.
  logic       cur_ack = 1'b1;
  logic [7:0] cur_d0 = '0, cur_d1 = '0;

  // Bus-level slave / protocol monitor (sees the master's intended SCL).
  logic       sda_line, scl_m, prev_sda, prev_scl;
  int         rise_cnt;
  logic [7:0] addr_rx;
  logic       mack_rx, mnack_rx;
  int         n_start = 0, n_stop = 0, pv_cnt = 0;

  assign sda_line = bus.sda_i;
  assign scl_m    = !bus.scl_oe;

  function automatic logic drive_for(int n);
    if (n == 8) return cur_ack;
    if (!cur_ack) return 1'b0;
    if (n >= 9 && n <= 16) return !cur_d0[16 - n];
    if (n >= 18 && n <= 25) return !cur_d1[25 - n];
    return 1'b0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slave_low <= 1'b0;
      rise_cnt  <= 0;
      prev_scl  <= 1'b1;
      prev_sda  <= 1'b1;
      addr_rx   <= '0;
      mack_rx   <= 1'b1;
      mnack_rx  <= 1'b0;
    end else begin
      prev_scl <= scl_m;
      prev_sda <= sda_line;
      if (prev_scl && scl_m && prev_sda && !sda_line) begin
        n_start   <= n_start + 1;
        rise_cnt  <= 0;
        slave_low <= 1'b0;
      end else if (prev_scl && scl_m && !prev_sda && sda_line) begin
        n_stop    <= n_stop + 1;
        slave_low <= 1'b0;
      end else if (!prev_scl && scl_m) begin
        if (rise_cnt < 8) addr_rx <= {addr_rx[6:0], sda_line};
        if (rise_cnt == 17) mack_rx <= sda_line;
        if (rise_cnt == 26) mnack_rx <= sda_line;
        rise_cnt <= rise_cnt + 1;
      end else if (prev_scl && !scl_m) begin
        slave_low <= drive_for(rise_cnt);
      end
    end
  end

  always @(posedge clk) if (pos_valid) pv_cnt <= pv_cnt + 1;

  // Reference model of the published outputs.
  logic [7:0] exp_pos = 8'h80;
  logic       exp_btn = 1'b0;
  logic       exp_nack = 1'b0;
  int         txns = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sda_oe"}, bus.sda_oe, 1'b0);
    check({tag, "_scl_oe"}, bus.scl_oe, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_pos"}, paddle_pos, exp_pos);
    check({tag, "_button"}, button, exp_btn);
    check({tag, "_nack"}, nack_err, exp_nack);
    check({tag, "_pos_valid"}, pos_valid, 1'b0);
  endtask

  // One poll: wait for START, let the slave answer, check timing and published results.
  task automatic run_txn(input logic ack, input logic [7:0] d0, input logic [7:0] d1,
                         input int start_lat, input bit drop_en, input bit do_stretch);
    int n, m, pv0, str_cnt, exp_len;
    bit str_started;
    cur_ack = ack;
    cur_d0  = d0;
    cur_d1  = d1;
    pv0     = pv_cnt;
    txns++;
    n = 0;
    while (!busy && n < 3 * POLL) begin
      @(negedge clk);
      n++;
    end
    check("start_latency", n, start_lat);
    m = 0;
    str_cnt = 0;
    str_started = 0;
    while (busy && m < 2000) begin
      if (drop_en && enable && rise_cnt == 12) enable = 1'b0;
      if (do_stretch) begin
        if (!str_started && !stretch && rise_cnt == 3 && bus.scl_oe) begin
          stretch = 1'b1;
        end else if (stretch && (str_started || !bus.scl_oe)) begin
          str_started = 1;
          if (str_cnt == 50) stretch = 1'b0;
          else str_cnt++;
        end
      end
      @(negedge clk);
      m++;
    end
    stretch = 1'b0;
    // START + STOP + address byte/ack, plus two data bytes with their acks on success.
    exp_len = (2 + 9 + (ack ? 18 : 0)) * 4 * (DIV + 1) + (do_stretch ? StretchExtra : 0);
    check("busy_len", m, exp_len);
    if (ack) begin
      exp_pos  = d0;
      exp_btn  = d1[0];
      exp_nack = 1'b0;
    end else begin
      exp_nack = 1'b1;
    end
    check("pos_valid_at_end", pos_valid, ack);
    check("paddle_pos", paddle_pos, exp_pos);
    check("button", button, exp_btn);
    check("nack_err", nack_err, exp_nack);
    check("addr_byte", addr_rx, EXP_ADDR);
    if (ack) begin
      check("master_ack0", mack_rx, 1'b0);
      check("master_nack1", mnack_rx, 1'b1);
    end
    @(negedge clk);
    check("pos_valid_pulse", pos_valid, 1'b0);
    check("pos_valid_count", pv_cnt - pv0, ack ? 1 : 0);
  endtask

  initial begin
    int seen, w;
    logic       a;
    logic [7:0] r0, r1;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    enable  = 1'b1;
    reset_n = 1'b1;

    run_txn(1'b1, 8'hC4, 8'h01, POLL, 0, 0);
    run_txn(1'b0, 8'h3C, 8'h00, POLL - 1, 0, 0);
    run_txn(1'b1, 8'h10, 8'h00, POLL - 1, 0, 0);

    for (int i = 0; i < 4; i++) begin
      a  = ($urandom_range(0, 3) != 0);
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      run_txn(a, r0, r1, POLL - 1, 0, 0);
    end

    // enable dropped mid RD0: frame still completes, then polling stops until re-enabled
    r0 = 8'($urandom);
    run_txn(1'b1, r0, 8'h01, POLL - 1, 1, 0);
    check("enable_low", enable, 1'b0);
    seen = 0;
    repeat (10 * POLL) begin
      @(negedge clk);
      if (busy) seen++;
    end
    check("no_poll_disabled", seen, 0);
    enable = 1'b1;
    run_txn(1'b1, 8'h5A, 8'h00, POLL, 0, 0);

    // SCL held low by the slave for 50 clks in the high phase of frame bit 3
    r0 = 8'($urandom);
    run_txn(1'b1, r0, 8'h03, POLL - 1, 0, 1);

    // reset mid RD1
    txns++;
    w = 0;
    while (!busy && w < 3 * POLL) begin
      @(negedge clk);
      w++;
    end
    w = 0;
    while (rise_cnt != 20 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("reached_rd1", rise_cnt, 20);
    reset_n = 1'b0;
    #1;
    exp_pos  = 8'h80;
    exp_btn  = 1'b0;
    exp_nack = 1'b0;
    check_idle_outputs("midreset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    r0 = 8'($urandom);
    run_txn(1'b1, r0, 8'h00, POLL, 0, 0);

    // Any SDA edge with SCL high other than START/STOP would inflate these counts.
    check("start_conditions", n_start, txns);
    check("stop_conditions", n_stop, txns - 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
